vga_frame_scheduler: RTL and testbench

//  Frame-synchronous update scheduler between the elevator core and the VGA pixel path.

---
 rtl/vga_frame_scheduler_if.sv | 22 ++
 rtl/vga_frame_scheduler.sv | 142 ++++++++++++++
 tb/tb_vga_frame_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_scheduler_if.sv
// Update handshake between elevator core and frame scheduler.
// Master drives the update request; slave returns ready.
interface vga_frame_scheduler_if;
    logic       upd_valid;
    logic [7:0] upd_dest;
    logic [1:0] upd_state;
    logic       upd_ready;

    modport master (
        output upd_valid,
        output upd_dest,
        output upd_state,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_dest,
        input  upd_state,
        output upd_ready
    );
endinterface

// File: rtl/vga_frame_scheduler.sv
// Frame-synchronous display update scheduler.
// Latches latest update, commits on vblank, blinks per frame.
module vga_frame_scheduler #(
    parameter int MIN_HOLD_FRAMES = 2,
    parameter int BLINK_FRAMES    = 30
) (
    input  logic                  pixel_clk,
    input  logic                  reset_n,
    input  logic                  vblank_pulse,
    vga_frame_scheduler_if.slave  upd,
    output logic [7:0]            disp_dest,
    output logic [1:0]            disp_state,
    output logic                  commit_pulse,
    output logic                  blink,
    output logic [7:0]            drop_cnt
);

    localparam int HW = (MIN_HOLD_FRAMES > 0) ?
                        $clog2(MIN_HOLD_FRAMES + 1) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT,
        HOLD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          do_commit;
    logic          drop_inc;
    logic          hold_inc;
    logic [7:0]    pend_dest;
    logic [1:0]    pend_state;
    logic          pend_flag;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [BW-1:0] blink_cnt;

    assign upd.upd_ready = reset_n && (state_q != COMMIT);
    assign accept        = upd.upd_valid && upd.upd_ready;
    assign hold_next     = hold_cnt + HW'(1);

    // State register.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        do_commit = 1'b0;
        drop_inc  = 1'b0;
        hold_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                drop_inc = accept;
                if (vblank_pulse) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_d   = (MIN_HOLD_FRAMES > 0) ? HOLD : IDLE;
            end
            HOLD: begin
                drop_inc = accept && pend_flag;
                if (vblank_pulse) begin
                    hold_inc = 1'b1;
                    if (hold_next == HOLD_MAX) begin
                        state_d = (pend_flag || accept) ?
                                  PENDING : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending capture, display load, hold and drop counters.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            pend_dest    <= '0;
            pend_state   <= '0;
            pend_flag    <= 1'b0;
            disp_dest    <= '0;
            disp_state   <= '0;
            commit_pulse <= 1'b0;
            hold_cnt     <= '0;
            drop_cnt     <= '0;
        end else begin
            commit_pulse <= do_commit;
            if (accept) begin
                pend_dest  <= upd.upd_dest;
                pend_state <= upd.upd_state;
                pend_flag  <= 1'b1;
            end
            if (do_commit) begin
                disp_dest  <= pend_dest;
                disp_state <= pend_state;
                pend_flag  <= 1'b0;
                hold_cnt   <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_next;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Frame-based blink, independent of scheduler state.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (vblank_pulse) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomized bench for vga_frame_scheduler.
// Reference model tracks pending data and frame budgets.
module tb_vga_frame_scheduler;

    localparam int TB_HOLD  = 2;
    localparam int TB_BLINK = 3;

    logic       pixel_clk;
    logic       reset_n;
    logic       vblank_pulse;
    logic [7:0] disp_dest;
    logic [1:0] disp_state;
    logic       commit_pulse;
    logic       blink;
    logic [7:0] drop_cnt;

    int checks;
    int failures;

    vga_frame_scheduler_if u_if ();

    vga_frame_scheduler #(
        .MIN_HOLD_FRAMES (TB_HOLD),
        .BLINK_FRAMES    (TB_BLINK)
    ) dut (
        .pixel_clk    (pixel_clk),
        .reset_n      (reset_n),
        .vblank_pulse (vblank_pulse),
        .upd          (u_if),
        .disp_dest    (disp_dest),
        .disp_state   (disp_state),
        .commit_pulse (commit_pulse),
        .blink        (blink),
        .drop_cnt     (drop_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Model: pending slot, frames still owed before a commit,
    // a commit in flight, and a running vblank count.
    logic [7:0] m_pend_d;
    logic [1:0] m_pend_s;
    bit         m_pend_v;
    int         m_hold;
    bit         m_commit;
    logic [7:0] m_disp_d;
    logic [1:0] m_disp_s;
    bit         m_pulse;
    int         m_drop;
    int         m_vb;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v,
                              input logic [7:0] d,
                              input logic [1:0] s,
                              input logic vb);
        bit acc;
        if (!r) begin
            m_pend_d = '0; m_pend_s = '0; m_pend_v = 0;
            m_hold = 0; m_commit = 0;
            m_disp_d = '0; m_disp_s = '0; m_pulse = 0;
            m_drop = 0; m_vb = 0;
            return;
        end
        acc = v && !m_commit;
        if (vb) m_vb++;
        if (m_commit) begin
            m_disp_d = m_pend_d;
            m_disp_s = m_pend_s;
            m_pulse  = 1;
            m_pend_v = 0;
            m_hold   = TB_HOLD;
            m_commit = 0;
        end else begin
            m_pulse = 0;
            if (vb) begin
                if (m_hold > 0) m_hold--;
                else if (m_pend_v) m_commit = 1;
            end
            if (acc) begin
                if (m_pend_v && m_drop < 255) m_drop++;
                m_pend_d = d;
                m_pend_s = s;
                m_pend_v = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [7:0] d,
                        input logic [1:0] s,
                        input logic vb);
        reset_n          = r;
        u_if.upd_valid   = v;
        u_if.upd_dest    = d;
        u_if.upd_state   = s;
        vblank_pulse     = vb;
        #1;
        chk("upd_ready", {31'b0, u_if.upd_ready},
            {31'b0, (r && !m_commit)});
        @(posedge pixel_clk);
        model_edge(r, v, d, s, vb);
        #1;
        chk("disp_dest", {24'b0, disp_dest}, {24'b0, m_disp_d});
        chk("disp_state", {30'b0, disp_state}, {30'b0, m_disp_s});
        chk("commit_pulse", {31'b0, commit_pulse}, {31'b0, m_pulse});
        chk("blink", {31'b0, blink},
            {31'b0, 1'(((m_vb / TB_BLINK) % 2) != 0)});
        chk("drop_cnt", {24'b0, drop_cnt}, m_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00, 2'b00, 0);
    endtask

    task automatic upd(input logic [7:0] d, input logic [1:0] s);
        step(1, 1, d, s, 0);
    endtask

    task automatic frame();
        step(1, 0, 8'h00, 2'b00, 1);
        idle(3);
    endtask

    initial begin
        bit prev_vb;
        checks   = 0;
        failures = 0;
        model_edge(0, 0, 8'h00, 2'b00, 0);

        step(0, 0, 8'h00, 2'b00, 0);
        step(0, 1, 8'hAA, 2'b11, 1);
        chk("rst_dest", {24'b0, disp_dest}, 32'h0);
        chk("rst_blink", {31'b0, blink}, 32'h0);

        upd(8'h04, 2'b01);
        step(1, 0, 8'h00, 2'b00, 1);
        idle(1);
        chk("t1_dest", {24'b0, disp_dest}, 32'h04);
        chk("t1_state", {30'b0, disp_state}, 32'h1);
        chk("t1_pulse", {31'b0, commit_pulse}, 32'h1);
        chk("t1_drop", {24'b0, drop_cnt}, 32'h0);
        idle(2);

        frame();
        frame();
        upd(8'h01, 2'b10);
        upd(8'h02, 2'b10);
        upd(8'h08, 2'b11);
        chk("t2_drop", {24'b0, drop_cnt}, 32'h2);
        step(1, 0, 8'h00, 2'b00, 1);
        idle(1);
        chk("t2_dest", {24'b0, disp_dest}, 32'h08);
        idle(2);

        frame();
        frame();
        upd(8'h01, 2'b00);
        idle(2);
        step(1, 1, 8'h10, 2'b01, 1);
        idle(1);
        chk("t3_dest", {24'b0, disp_dest}, 32'h10);

        upd(8'h20, 2'b10);
        frame();
        chk("t4_vb1", {24'b0, disp_dest}, 32'h10);
        frame();
        chk("t4_vb2", {24'b0, disp_dest}, 32'h10);
        frame();
        chk("t4_vb3", {24'b0, disp_dest}, 32'h20);

        idle(2);
        for (int i = 0; i < 7; i++) frame();

        frame();
        frame();
        upd(8'hFF, 2'b11);
        step(0, 0, 8'h00, 2'b00, 0);
        chk("t6_dest", {24'b0, disp_dest}, 32'h0);
        chk("t6_drop", {24'b0, drop_cnt}, 32'h0);
        frame();
        chk("t6_nocommit", {24'b0, disp_dest}, 32'h0);

        for (int i = 0; i < 300; i++) upd(8'(i), 2'(i));
        chk("sat_drop", {24'b0, drop_cnt}, 32'hFF);
        idle(1);
        step(0, 0, 8'h00, 2'b00, 0);

        prev_vb = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, v, vb;
            r  = ($urandom_range(0, 299) != 0);
            v  = ($urandom_range(0, 2) == 0);
            vb = !prev_vb && ($urandom_range(0, 9) == 0);
            prev_vb = vb;
            step(r, v, 8'($urandom), 2'($urandom), vb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
